// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter, MSB-first, one bit per clock, followed by a programmable idle gap.
// Optional build macro SEQ_GEN_REPEAT_EN adds repeat_en/stop ports for continuous re-transmission.
//
// state   | meaning
// S_IDLE  | waiting for start_valid; start_ready high
// S_SHIFT | driving one pattern bit per cycle, bit_cnt = index of bit on seqOut
// S_GAP   | idle gap after last bit, gap_cnt counts down to 0
module seq_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_en,
  input  logic             stop,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [GAP_W-1:0] gap,
  output logic             seqOut,
  output logic             seqValid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t             state, nxt_state;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [GAP_W-1:0]   gap_q;
  logic [LEN_W-1:0]   bit_cnt, nxt_bit;
  logic [GAP_W-1:0]   gap_cnt, nxt_gap;
  logic [LEN_W-1:0]   len_eff;
  logic [PAT_W-1:0]   sel_src;
  logic [LEN_W-1:0]   sel_idx;
  logic               nxt_out, nxt_valid, nxt_done, restart, accept, again;

  assign start_ready = (state == S_IDLE);
  assign accept      = (state == S_IDLE) && start_valid;
  assign len_eff     = (pat_len == '0 || pat_len > LEN_MAX) ? LEN_MAX : pat_len;

`ifdef SEQ_GEN_REPEAT_EN
  logic rep_q, stop_q;

  // stop is sticky for the rest of the transmission; the current pass still completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q  <= 1'b0;
      stop_q <= 1'b0;
    end else if (accept) begin
      rep_q  <= repeat_en;
      stop_q <= 1'b0;
    end else if (stop && state != S_IDLE) begin
      stop_q <= 1'b1;
    end
  end

  assign again = rep_q && !stop_q && !stop;
`else
  assign again = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_bit   = bit_cnt;
    nxt_gap   = gap_cnt;
    nxt_valid = 1'b0;
    nxt_done  = 1'b0;
    restart   = 1'b0;
    sel_src   = pat_q;
    sel_idx   = bit_cnt - LEN_ONE;
    case (state)
      S_IDLE: begin
        if (start_valid) begin
          nxt_state = S_SHIFT;
          nxt_bit   = len_eff - LEN_ONE;
          sel_src   = pattern;
          sel_idx   = len_eff - LEN_ONE;
          nxt_valid = 1'b1;
          nxt_done  = (len_eff == LEN_ONE);
        end
      end
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          nxt_bit   = bit_cnt - LEN_ONE;
          nxt_valid = 1'b1;
          nxt_done  = (bit_cnt == LEN_ONE);
        end else if (gap_q != '0) begin
          nxt_state = S_GAP;
          nxt_gap   = gap_q - GAP_ONE;
        end else if (again) begin
          restart = 1'b1;
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) nxt_gap = gap_cnt - GAP_ONE;
        else if (again)    restart = 1'b1;
        else               nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
    if (restart) begin
      nxt_state = S_SHIFT;
      nxt_bit   = len_q - LEN_ONE;
      sel_idx   = len_q - LEN_ONE;
      nxt_valid = 1'b1;
      nxt_done  = (len_q == LEN_ONE);
    end
    nxt_out = nxt_valid && |(sel_src & (PAT_W'(1) << sel_idx));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      seqOut   <= 1'b0;
      seqValid <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (accept) begin
        pat_q <= pattern;
        len_q <= len_eff;
        gap_q <= gap;
      end
      state    <= nxt_state;
      bit_cnt  <= nxt_bit;
      gap_cnt  <= nxt_gap;
      seqOut   <= nxt_out;
      seqValid <= nxt_valid;
      done     <= nxt_done;
      busy     <= (nxt_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed and randomized checks of seq_gen against a per-cycle arithmetic model of the transmission.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_valid = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic [3:0] gap = '0;
  logic       start_ready, seqOut, seqValid, busy, done;
`ifdef SEQ_GEN_REPEAT_EN
  logic       repeat_en = 1'b0;
  logic       stop = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  seq_gen #(.PAT_W(8), .LEN_W(4), .GAP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_en   (repeat_en),
    .stop        (stop),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .gap         (gap),
    .seqOut      (seqOut),
    .seqValid    (seqValid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic eo, input logic ev,
                          input logic ed, input logic eb, input logic er);
    chk({tag, ".seqOut"},      seqOut,      eo);
    chk({tag, ".seqValid"},    seqValid,    ev);
    chk({tag, ".done"},        done,        ed);
    chk({tag, ".busy"},        busy,        eb);
    chk({tag, ".start_ready"}, start_ready, er);
  endtask

  // Called just after a falling edge; returns at the falling edge of the first idle cycle.
  task automatic send(input string tag, input logic [7:0] p, input logic [3:0] len_in,
                      input logic [3:0] g, input bit hold);
    int         len;
    logic [7:0] tmp;
    logic       ev, eo;
    len = (len_in == 0 || len_in > 8) ? 8 : int'(len_in);
    chk({tag, ".ready_pre"}, start_ready, 1'b1);
    pattern     = p;
    pat_len     = len_in;
    gap         = g;
    start_valid = 1'b1;
    for (int c = 1; c <= len + int'(g) + 1; c++) begin
      @(negedge clk);
      if (!hold) start_valid = 1'b0;
      pattern = 8'($urandom);
      pat_len = 4'($urandom);
      gap     = 4'($urandom);
      ev  = (c <= len);
      tmp = p >> (len - c);
      eo  = ev & tmp[0];
      chk_outs(tag, eo, ev, c == len, c <= len + int'(g), c == len + int'(g) + 1);
    end
  endtask

  initial begin
    logic [7:0] tmp;
    // reset state
    @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send("m1001", 8'h09, 4'd4, 4'd0, 1'b0);
    send("a5_len0", 8'hA5, 4'd0, 4'd2, 1'b0);
    send("len_clamp", 8'h5C, 4'd13, 4'd1, 1'b0);
    // held start_valid: second accept only once the first pass and gap are over
    send("hold1", 8'h03, 4'd2, 4'd3, 1'b1);
    send("hold2", 8'h03, 4'd2, 4'd3, 1'b0);
    send("len1", 8'hF1, 4'd1, 4'd0, 1'b0);
    send("len1_zero", 8'hFE, 4'd1, 4'd2, 1'b0);

    // asynchronous reset during bit 2 of a 6-bit pattern
    pattern = 8'h2D; pat_len = 4'd6; gap = 4'd2; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tmp = 8'h2D >> 3;
    chk_outs("pre_abort", tmp[0], 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk_outs("abort_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_outs("abort_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_outs("no_resume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    send("after_abort", 8'h96, 4'd6, 4'd1, 1'b0);

    for (int i = 0; i < 16; i++)
      send("rand", 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);

`ifdef SEQ_GEN_REPEAT_EN
    // repeat 1001 with gap 1; stop pulsed in the third pass ends after that pass and its gap
    begin
      int   p, o;
      logic ev, eo;
      repeat_en = 1'b1; pattern = 8'h09; pat_len = 4'd4; gap = 4'd1; start_valid = 1'b1;
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        start_valid = 1'b0;
        repeat_en   = 1'b0;
        pattern     = 8'($urandom);
        stop        = (c == 12);
        p   = (c - 1) / 5;
        o   = (c - 1) % 5 + 1;
        ev  = (p < 3) && (o <= 4);
        tmp = 8'h09 >> (4 - o);
        eo  = ev & tmp[0];
        chk_outs("repeat", eo, ev, (p < 3) && (o == 4), p < 3, p >= 3);
      end
      stop = 1'b1;
      send("stop_idle", 8'h06, 4'd3, 4'd0, 1'b0);
      stop = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
